pick_frame_monitor: RTL and testbench
=====================================

Name: pick_frame_monitor

Overview:
- Consumer-side counterpart of the pick-two sprite renderer. It reads the renderer's per-pixel show signal on the same drawX/drawY raster scan and accumulates frame statistics: lit-pixel count, bounding box, and pixel overlap with a target sprite such as the player.
- Once per frame it publishes the statistics to game logic with a valid/ack handshake.
- Sits beside the colour mapper, driven by the VGA controller's coordinates and frame sync.

Parameters:
- H_ACTIVE, 640, visible columns; pixels with drawX >= H_ACTIVE are ignored.
- V_ACTIVE, 480, visible rows; pixels with drawY >= V_ACTIVE are ignored.
- CNT_W, 19, width of the pixel counters; must satisfy 2^CNT_W > H_ACTIVE*V_ACTIVE.

Ports:
- CLK  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- pixel_en  in  1  current drawX/drawY is a valid pixel this cycle.
- drawX  in  10  current scan column.
- drawY  in  10  current scan row.
- show_pick  in  1  pick-two sprite lit at (drawX, drawY).
- show_target  in  1  target sprite lit at (drawX, drawY).
- frame_sync  in  1  one-cycle pulse marking end of the visible frame.
- result_ack  in  1  consumer accepts the current result.
- result_valid  out  1  published result pending.
- pick_count  out  CNT_W  lit pick pixels in the last frame.
- overlap_count  out  CNT_W  pixels where show_pick & show_target.
- hit  out  1  overlap_count != 0.
- min_x, max_x, min_y, max_y  out  10 each  bounding box of lit pick pixels.
- bbox_empty  out  1  no lit pick pixel in the last frame.
- overrun  out  1  sticky: an unacknowledged result was overwritten.

Behaviour:
- Reset (synchronous, checked every edge, overrides everything):
  - State returns to IDLE.
  - All outputs and accumulators are 0, except min_x/min_y = 1023 and bbox_empty = 1.
- Reset mid-frame: the partial frame is discarded and nothing is published.
- States:
  - IDLE: ignore pixels. On frame_sync, clear the accumulators and go to ACCUM. No result is published, because the frame was partial.
  - ACCUM: accumulate pixels. On frame_sync, publish and clear the accumulators in the same edge, then stay in ACCUM.
- Accumulation: an accepted pixel has pixel_en=1, drawX < H_ACTIVE, drawY < V_ACTIVE, and show_pick=1.
  - For each accepted pixel: acc_cnt += 1, saturating at 2^CNT_W-1.
  - Also for each accepted pixel: acc_minx = min(acc_minx, drawX), acc_maxx = max(acc_maxx, drawX), and the same for y.
  - If show_target is also 1: acc_ovl += 1, saturating.
  - Accumulator clear values: cnt = 0, ovl = 0, minx/miny = 1023, maxx/maxy = 0.
- Pixel on the same cycle as frame_sync: the pixel counts toward the closing frame, and its contribution appears in the published values.
- Publish (registered): outputs update on the frame_sync edge, so values are visible the cycle after frame_sync.
  - result_valid is set to 1.
  - hit = (acc_ovl incl. current pixel) != 0.
  - bbox_empty = (acc_cnt incl. current pixel) == 0.
- Empty frame: pick_count = 0, bbox_empty = 1, min_x = min_y = 1023, max_x = max_y = 0, hit = 0.
- Handshake:
  - result_ack while result_valid=1 clears result_valid on the next edge.
  - Data outputs hold until the next publish.
  - result_ack while result_valid=0 is ignored.
- Simultaneous publish and ack: the publish wins. result_valid stays 1, the new data is loaded, and overrun is not set.
- Overrun: a publish while result_valid=1 without ack sets overrun=1, and the new data replaces the old. overrun clears only on Reset.
- Latency: one cycle from frame_sync to new outputs; one cycle from result_ack to result_valid=0.
- Arithmetic: all comparisons are unsigned 10-bit. Counters are CNT_W-bit with saturation (no wrap).

Test Plan:
- Reset, then frame_sync, then a 640x480 scan with show_pick lit only in the 11x11 square at x = 100..110, y = 200..210 -> the first frame_sync publishes nothing; the second gives pick_count = 121, bbox (100,110,200,210), bbox_empty = 0, result_valid = 1.
- show_target lit over x = 105..120 on the same square -> overlap_count = 6*11 = 66, hit = 1. result_ack the cycle after publish -> result_valid = 0 the next cycle, data held.
- Scan with show_pick = 0 everywhere -> pick_count = 0, bbox_empty = 1, min_x = 1023, max_x = 0, hit = 0.
- Pixel at (639,479) lit with frame_sync asserted on the same cycle -> it is included: max_x = 639, max_y = 479. Pixel at drawX = 700 lit -> ignored.
- Two publishes without ack -> overrun = 1 and the second frame's data is shown. Repeat with result_ack coincident with frame_sync -> overrun stays 0 and result_valid stays 1.
- Reset asserted mid-scan -> outputs return to reset values immediately, and the next frame_sync only re-arms (result_valid stays 0).

Source files
------------

// File: rtl/pick_frame_monitor.sv
// Per-frame statistics for the pick-two sprite: lit-pixel count, bounding box and
// overlap with a target sprite, published once per frame over a valid/ack handshake.
module pick_frame_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned CNT_W    = 19
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             pixel_en,
    input  logic [9:0]       drawX,
    input  logic [9:0]       drawY,
    input  logic             show_pick,
    input  logic             show_target,
    input  logic             frame_sync,
    input  logic             result_ack,
    output logic             result_valid,
    output logic [CNT_W-1:0] pick_count,
    output logic [CNT_W-1:0] overlap_count,
    output logic             hit,
    output logic [9:0]       min_x,
    output logic [9:0]       max_x,
    output logic [9:0]       min_y,
    output logic [9:0]       max_y,
    output logic             bbox_empty,
    output logic             overrun
);

    localparam int unsigned COORD_W = 10;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic [0:0] {S_IDLE, S_ACCUM} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d, acc_ovl_q, acc_ovl_d;
    logic [COORD_W-1:0] acc_minx_q, acc_minx_d, acc_maxx_q, acc_maxx_d;
    logic [COORD_W-1:0] acc_miny_q, acc_miny_d, acc_maxy_q, acc_maxy_d;

    logic               result_valid_q, result_valid_d;
    logic [CNT_W-1:0]   pick_count_q, pick_count_d, overlap_count_q, overlap_count_d;
    logic               hit_q, hit_d, bbox_empty_q, bbox_empty_d, overrun_q, overrun_d;
    logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;

    // Accumulator values including the current pixel (used for both update and publish)
    logic               accept_c;
    logic [CNT_W-1:0]   cnt_c, ovl_c;
    logic [COORD_W-1:0] minx_c, maxx_c, miny_c, maxy_c;

    always_comb begin
        accept_c = pixel_en && (drawX < COORD_W'(H_ACTIVE)) && (drawY < COORD_W'(V_ACTIVE))
                   && show_pick;
        cnt_c  = acc_cnt_q;
        ovl_c  = acc_ovl_q;
        minx_c = acc_minx_q;
        maxx_c = acc_maxx_q;
        miny_c = acc_miny_q;
        maxy_c = acc_maxy_q;
        if (accept_c) begin
            if (acc_cnt_q != CNT_MAX) cnt_c = acc_cnt_q + CNT_W'(1);
            if (show_target && (acc_ovl_q != CNT_MAX)) ovl_c = acc_ovl_q + CNT_W'(1);
            if (drawX < acc_minx_q) minx_c = drawX;
            if (drawX > acc_maxx_q) maxx_c = drawX;
            if (drawY < acc_miny_q) miny_c = drawY;
            if (drawY > acc_maxy_q) maxy_c = drawY;
        end
    end

    // Next-state, accumulator and published-result logic
    always_comb begin
        state_d         = state_q;
        acc_cnt_d       = acc_cnt_q;
        acc_ovl_d       = acc_ovl_q;
        acc_minx_d      = acc_minx_q;
        acc_maxx_d      = acc_maxx_q;
        acc_miny_d      = acc_miny_q;
        acc_maxy_d      = acc_maxy_q;
        result_valid_d  = result_valid_q;
        pick_count_d    = pick_count_q;
        overlap_count_d = overlap_count_q;
        hit_d           = hit_q;
        bbox_empty_d    = bbox_empty_q;
        overrun_d       = overrun_q;
        min_x_d         = min_x_q;
        max_x_d         = max_x_q;
        min_y_d         = min_y_q;
        max_y_d         = max_y_q;

        if (result_ack && result_valid_q) result_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_sync) begin
                    state_d    = S_ACCUM;
                    acc_cnt_d  = '0;
                    acc_ovl_d  = '0;
                    acc_minx_d = COORD_MAX;
                    acc_maxx_d = '0;
                    acc_miny_d = COORD_MAX;
                    acc_maxy_d = '0;
                end
            end
            S_ACCUM: begin
                if (frame_sync) begin
                    // Publish beats a coincident ack; overrun only when old result was never taken
                    result_valid_d  = 1'b1;
                    overrun_d       = overrun_q | (result_valid_q & ~result_ack);
                    pick_count_d    = cnt_c;
                    overlap_count_d = ovl_c;
                    hit_d           = (ovl_c != '0);
                    bbox_empty_d    = (cnt_c == '0);
                    min_x_d         = minx_c;
                    max_x_d         = maxx_c;
                    min_y_d         = miny_c;
                    max_y_d         = maxy_c;
                    acc_cnt_d       = '0;
                    acc_ovl_d       = '0;
                    acc_minx_d      = COORD_MAX;
                    acc_maxx_d      = '0;
                    acc_miny_d      = COORD_MAX;
                    acc_maxy_d      = '0;
                end else begin
                    acc_cnt_d  = cnt_c;
                    acc_ovl_d  = ovl_c;
                    acc_minx_d = minx_c;
                    acc_maxx_d = maxx_c;
                    acc_miny_d = miny_c;
                    acc_maxy_d = maxy_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            acc_cnt_q       <= '0;
            acc_ovl_q       <= '0;
            acc_minx_q      <= COORD_MAX;
            acc_maxx_q      <= '0;
            acc_miny_q      <= COORD_MAX;
            acc_maxy_q      <= '0;
            result_valid_q  <= 1'b0;
            pick_count_q    <= '0;
            overlap_count_q <= '0;
            hit_q           <= 1'b0;
            bbox_empty_q    <= 1'b1;
            overrun_q       <= 1'b0;
            min_x_q         <= COORD_MAX;
            max_x_q         <= '0;
            min_y_q         <= COORD_MAX;
            max_y_q         <= '0;
        end else begin
            state_q         <= state_d;
            acc_cnt_q       <= acc_cnt_d;
            acc_ovl_q       <= acc_ovl_d;
            acc_minx_q      <= acc_minx_d;
            acc_maxx_q      <= acc_maxx_d;
            acc_miny_q      <= acc_miny_d;
            acc_maxy_q      <= acc_maxy_d;
            result_valid_q  <= result_valid_d;
            pick_count_q    <= pick_count_d;
            overlap_count_q <= overlap_count_d;
            hit_q           <= hit_d;
            bbox_empty_q    <= bbox_empty_d;
            overrun_q       <= overrun_d;
            min_x_q         <= min_x_d;
            max_x_q         <= max_x_d;
            min_y_q         <= min_y_d;
            max_y_q         <= max_y_d;
        end
    end

    assign result_valid  = result_valid_q;
    assign pick_count    = pick_count_q;
    assign overlap_count = overlap_count_q;
    assign hit           = hit_q;
    assign bbox_empty    = bbox_empty_q;
    assign overrun       = overrun_q;
    assign min_x         = min_x_q;
    assign max_x         = max_x_q;
    assign min_y         = min_y_q;
    assign max_y         = max_y_q;

endmodule

// File: tb/tb_pick_frame_monitor.sv
// Directed bench for pick_frame_monitor: windowed raster scans with hand-computed
// frame statistics, handshake, overrun and reset cases.
module tb_pick_frame_monitor;

    localparam int unsigned CNT_W = 19;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             pixel_en;
    logic [9:0]       drawX, drawY;
    logic             show_pick, show_target, frame_sync, result_ack;
    logic             result_valid, hit, bbox_empty, overrun;
    logic [CNT_W-1:0] pick_count, overlap_count;
    logic [9:0]       min_x, max_x, min_y, max_y;

    int n_checks = 0;
    int n_pass   = 0;

    pick_frame_monitor #(.H_ACTIVE(640), .V_ACTIVE(480), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .pixel_en(pixel_en), .drawX(drawX), .drawY(drawY),
        .show_pick(show_pick), .show_target(show_target), .frame_sync(frame_sync),
        .result_ack(result_ack), .result_valid(result_valid), .pick_count(pick_count),
        .overlap_count(overlap_count), .hit(hit), .min_x(min_x), .max_x(max_x),
        .min_y(min_y), .max_y(max_y), .bbox_empty(bbox_empty), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    // Apply one cycle of inputs, then step to just after the rising edge
    task automatic drive(input int x, input int y, input logic en, input logic pick,
                         input logic tgt, input logic fs, input logic ack);
        drawX       = 10'(x);
        drawY       = 10'(y);
        pixel_en    = en;
        show_pick   = pick;
        show_target = tgt;
        frame_sync  = fs;
        result_ack  = ack;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_count", 32'(pick_count), 0);
        check("rst_min_x", 32'(min_x), 1023);
        check("rst_min_y", 32'(min_y), 1023);
        check("rst_max_x", 32'(max_x), 0);
        check("rst_empty", 32'(bbox_empty), 1);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_hit", 32'(hit), 0);
        Reset = 1'b0;

        // First frame_sync only arms; the lit pixel with it is ignored in IDLE
        drive(100, 200, 1, 1, 1, 1, 0);
        check("arm_valid", 32'(result_valid), 0);

        // Window scan: 11x11 square at (100..110, 200..210), target over x=105..120
        for (int y = 196; y <= 214; y++) begin
            for (int x = 96; x <= 124; x++) begin
                logic p, t;
                p = (x >= 100 && x <= 110 && y >= 200 && y <= 210);
                t = (x >= 105 && x <= 120 && y >= 200 && y <= 210);
                drive(x, y, 1, p, t, 0, 0);
            end
        end
        drive(700, 205, 1, 1, 1, 0, 0);
        drive(50, 50, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("sq_valid", 32'(result_valid), 1);
        check("sq_count", 32'(pick_count), 121);
        check("sq_overlap", 32'(overlap_count), 66);
        check("sq_hit", 32'(hit), 1);
        check("sq_min_x", 32'(min_x), 100);
        check("sq_max_x", 32'(max_x), 110);
        check("sq_min_y", 32'(min_y), 200);
        check("sq_max_y", 32'(max_y), 210);
        check("sq_empty", 32'(bbox_empty), 0);

        drive(0, 0, 0, 0, 0, 0, 1);
        check("ack_valid", 32'(result_valid), 0);
        check("ack_hold_count", 32'(pick_count), 121);
        check("ack_hold_max_y", 32'(max_y), 210);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("ack_idle_valid", 32'(result_valid), 0);

        // Empty frame
        for (int x = 0; x < 20; x++) drive(x, 3, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("empty_valid", 32'(result_valid), 1);
        check("empty_count", 32'(pick_count), 0);
        check("empty_bbox", 32'(bbox_empty), 1);
        check("empty_min_x", 32'(min_x), 1023);
        check("empty_max_x", 32'(max_x), 0);
        check("empty_min_y", 32'(min_y), 1023);
        check("empty_max_y", 32'(max_y), 0);
        check("empty_hit", 32'(hit), 0);
        check("empty_overrun", 32'(overrun), 0);

        // Corner pixel coincident with frame_sync; previous result left unacked
        drive(5, 7, 1, 1, 0, 0, 0);
        drive(639, 479, 1, 1, 1, 1, 0);
        check("corner_count", 32'(pick_count), 2);
        check("corner_overlap", 32'(overlap_count), 1);
        check("corner_max_x", 32'(max_x), 639);
        check("corner_max_y", 32'(max_y), 479);
        check("corner_min_x", 32'(min_x), 5);
        check("corner_min_y", 32'(min_y), 7);
        check("corner_hit", 32'(hit), 1);
        check("overrun_set", 32'(overrun), 1);
        check("overrun_valid", 32'(result_valid), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("overrun_sticky", 32'(overrun), 1);

        // Reset clears overrun; then publish with coincident ack
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        check("rst2_overrun", 32'(overrun), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(3, 4, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("pub1_valid", 32'(result_valid), 1);
        check("pub1_count", 32'(pick_count), 1);
        drive(8, 9, 1, 1, 0, 0, 0);
        drive(10, 11, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        check("pubak_valid", 32'(result_valid), 1);
        check("pubak_overrun", 32'(overrun), 0);
        check("pubak_count", 32'(pick_count), 2);
        check("pubak_max_x", 32'(max_x), 10);
        check("pubak_min_y", 32'(min_y), 9);

        // Reset mid-scan
        drive(30, 40, 1, 1, 1, 0, 0);
        Reset = 1'b1;
        drive(31, 40, 1, 1, 1, 0, 0);
        Reset = 1'b0;
        check("mid_valid", 32'(result_valid), 0);
        check("mid_count", 32'(pick_count), 0);
        check("mid_min_x", 32'(min_x), 1023);
        check("mid_max_y", 32'(max_y), 0);
        check("mid_empty", 32'(bbox_empty), 1);
        check("mid_overlap", 32'(overlap_count), 0);
        drive(32, 40, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("rearm_valid", 32'(result_valid), 0);
        check("rearm_count", 32'(pick_count), 0);
        drive(20, 30, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("post_valid", 32'(result_valid), 1);
        check("post_count", 32'(pick_count), 1);
        check("post_min_x", 32'(min_x), 20);
        check("post_hit", 32'(hit), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
